seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the vending machine's multi-digit 7-segment display. A single BCD-to-7-segment decoder is shared across N_DIGITS digits. The block holds a frame of BCD digits, presents one nibble at a time on `bcd_out` to the decoder, and drives the matching active-low anode. Dead-time blanking between digits prevents ghosting. Display updates are double-buffered so digits never tear mid-frame.

---
 rtl/seg7_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan controller for an N-digit 7-seg display.
// Shares one BCD decoder across all digits; double-buffered frames; dead-time blanking.
// Ports:
//   clk, reset (async, active-high), enable, load, digits_in[4*N-1:0], lz_en
//   bcd_out[3:0] (to decoder), anode[N-1:0] (active-low), frame_done (1-cycle pulse)
module seg7_scan_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  lz_en,
  output logic [3:0]            bcd_out,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_done
);

  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = $clog2(N_DIGITS);

  typedef enum logic [1:0] {OFF, BLANK, DRIVE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] active;
  logic [4*N_DIGITS-1:0] pending;
  logic                  pend_valid;

  logic [IW-1:0]         idx_next;
  logic                  drive_end;
  logic                  boundary;
  logic [4*N_DIGITS-1:0] active_next;
  logic [N_DIGITS-1:0]   supp;
  logic                  allz;
  logic [N_DIGITS-1:0]   sel;

  assign idx_next  = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
  assign drive_end = (state == DRIVE) && (cnt == CW'(REFRESH_DIV - 1));
  assign boundary  = enable && drive_end && (idx == IW'(N_DIGITS - 1));
  assign sel       = N_DIGITS'(1) << idx;

  // A load landing on the boundary edge bypasses pending and goes live at once.
  always_comb begin
    active_next = active;
    if (boundary) begin
      if (load)
        active_next = digits_in;
      else if (pend_valid)
        active_next = pending;
    end
  end

  // Digit k>0 blanks when it and every digit above it are zero.
  always_comb begin
    allz = 1'b1;
    supp = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      allz    = allz & (active[4*k +: 4] == 4'd0);
      supp[k] = lz_en & allz;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= OFF;
      cnt        <= '0;
      idx        <= '0;
      anode      <= '1;
      bcd_out    <= 4'd0;
      frame_done <= 1'b0;
      active     <= '0;
      pending    <= '0;
      pend_valid <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        pending    <= digits_in;
        pend_valid <= 1'b1;
      end
      if (!enable) begin
        state <= OFF;
        cnt   <= '0;
        idx   <= '0;
        anode <= '1;
      end else begin
        unique case (state)
          OFF: begin
            state   <= BLANK;
            cnt     <= '0;
            anode   <= '1;
            bcd_out <= active[3:0];
          end
          BLANK: begin
            if (cnt == CW'(BLANK_CYCLES - 1)) begin
              state <= DRIVE;
              cnt   <= '0;
              anode <= supp[idx] ? '1 : ~sel;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DRIVE: begin
            if (drive_end) begin
              state   <= BLANK;
              cnt     <= '0;
              idx     <= idx_next;
              anode   <= '1;
              active  <= active_next;
              // Present the next nibble now so it settles during blanking.
              bcd_out <= active_next[{idx_next, 2'b00} +: 4];
              if (boundary) begin
                frame_done <= 1'b1;
                pend_valid <= 1'b0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= OFF;
            anode <= '1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed bench for seg7_scan_ctrl (N=4, REFRESH_DIV=4, BLANK=1).
// Scoreboard of expected {anode, bcd} per driven digit, plus continuous anode/bcd sanity.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  anode;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seg7_scan_ctrl #(
    .N_DIGITS(4),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .digits_in(digits_in),
    .lz_en(lz_en),
    .bcd_out(bcd_out),
    .anode(anode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(logic [3:0] an, logic [3:0] bcd);
    exp_t e;
    e.an  = an;
    e.bcd = bcd;
    sb.push_back(e);
  endtask

  task automatic wait_fd(int maxc);
    @(negedge clk);
    for (int i = 0; i < maxc && !frame_done; i++)
      @(negedge clk);
    chk("frame_done_wait", {7'd0, frame_done}, 8'd1);
  endtask

  // Monitor: ghosting, one-hot anode, frame period, scoreboard on digit entry.
  logic [3:0] prev_an  = 4'hF;
  logic [3:0] prev_bcd = 4'h0;
  int         cycle    = 0;
  int         last_fd  = 0;
  bit         armed    = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    cycle++;
    chk("onehot_anode", {7'd0, ($countones(~anode) <= 1)}, 8'd1);
    if (prev_an == 4'hF && anode != 4'hF) begin
      chk("bcd_settled", {4'd0, bcd_out}, {4'd0, prev_bcd});
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_anode", {4'd0, anode}, {4'd0, e.an});
        chk("sb_bcd", {4'd0, bcd_out}, {4'd0, e.bcd});
      end
    end
    if (reset || !enable) begin
      armed = 1'b0;
    end else if (frame_done) begin
      if (armed)
        chk("frame_period", 8'(cycle - last_fd), 8'd20);
      last_fd = cycle;
      armed   = 1'b1;
    end
    prev_an  = anode;
    prev_bcd = bcd_out;
  end

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0;
    lz_en     = 1'b0;
    cyc(3);
    chk("rst_anode", {4'd0, anode}, 8'h0F);
    chk("rst_bcd", {4'd0, bcd_out}, 8'h00);
    chk("rst_fd", {7'd0, frame_done}, 8'd0);
    reset = 1'b0;
    cyc(2);

    // Enable and load together; first slot precedes the swap.
    enable    = 1'b1;
    load      = 1'b1;
    digits_in = 16'h4321;
    cyc(1);
    load = 1'b0;
    chk("en_blank", {4'd0, anode}, 8'h0F);
    cyc(1);
    chk("en_first_an", {4'd0, anode}, 8'h0E);
    chk("en_first_bcd", {4'd0, bcd_out}, 8'h00);
    wait_fd(40);
    chk("swap_bcd0", {4'd0, bcd_out}, 8'h01);

    // Frame A shows 4321; load 9876 during digit 1.
    push(4'hE, 4'h1); push(4'hD, 4'h2);
    push(4'hB, 4'h3); push(4'h7, 4'h4);
    cyc(7);
    chk("d1_drive", {4'd0, anode}, 8'h0D);
    load = 1'b1; digits_in = 16'h9876;
    cyc(1);
    load = 1'b0;
    wait_fd(25);

    // Frame B shows 9876; two loads, the later one wins.
    push(4'hE, 4'h6); push(4'hD, 4'h7);
    push(4'hB, 4'h8); push(4'h7, 4'h9);
    cyc(7);
    load = 1'b1; digits_in = 16'h1234;
    cyc(1);
    load = 1'b0;
    cyc(4);
    load = 1'b1; digits_in = 16'h5555;
    cyc(1);
    load = 1'b0;
    wait_fd(25);

    // Frame C shows 5555; load 0070 on the boundary edge.
    push(4'hE, 4'h5); push(4'hD, 4'h5);
    push(4'hB, 4'h5); push(4'h7, 4'h5);
    lz_en = 1'b1;
    cyc(19);
    load = 1'b1; digits_in = 16'h0070;
    cyc(1);
    load = 1'b0;
    chk("bnd_fd", {7'd0, frame_done}, 8'd1);
    chk("bnd_bcd0", {4'd0, bcd_out}, 8'h00);
    push(4'hE, 4'h0); push(4'hD, 4'h7);
    cyc(10);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("lz_blank", {4'd0, anode}, 8'h0F);
    end
    chk("lz_fd", {7'd0, frame_done}, 8'd1);

    // Suppression off; disable during digit 2.
    lz_en = 1'b0;
    push(4'hE, 4'h0); push(4'hD, 4'h7); push(4'hB, 4'h0);
    cyc(12);
    chk("d2_drive", {4'd0, anode}, 8'h0B);
    enable = 1'b0;
    cyc(1);
    chk("dis_anode", {4'd0, anode}, 8'h0F);
    for (int i = 0; i < 25; i++) begin
      chk("dis_no_fd", {7'd0, frame_done}, 8'd0);
      chk("dis_off", {4'd0, anode}, 8'h0F);
      cyc(1);
    end
    enable = 1'b1;
    cyc(1);
    chk("reen_blank", {4'd0, anode}, 8'h0F);
    cyc(1);
    chk("reen_an", {4'd0, anode}, 8'h0E);
    chk("reen_bcd", {4'd0, bcd_out}, 8'h00);

    // Asynchronous reset mid-drive.
    cyc(1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_anode", {4'd0, anode}, 8'h0F);
    chk("arst_bcd", {4'd0, bcd_out}, 8'h00);
    chk("arst_fd", {7'd0, frame_done}, 8'd0);
    push(4'hE, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    cyc(6);
    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
